zigzag_pingpong_buffer: RTL and testbench

Double-buffered (ping-pong) 8x8 coefficient block buffer for the JPEG encoder path, between the DCT/quantiser row output and the entropy coder.
- Accepts one 8-coefficient row per write handshake.
- Emits each completed block in zigzag order, OUT_LANES coefficients per read beat.
- Valid/ready flow control on both sides; one bank fills while the other drains, so back-to-back blocks flow without stalls.

---
 rtl/jpeg_zz_pkg.sv | 36 +++
 rtl/zz_bank.sv | 48 ++++
 rtl/zigzag_pingpong_buffer.sv | 176 +++++++++++++++++
 tb/tb_zigzag_pingpong_buffer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/jpeg_zz_pkg.sv
// jpeg_zz_pkg: shared constants for the JPEG zigzag ping-pong block buffer.
//   BLK_DIM / BLK_SIZE : 8x8 block geometry.
//   ZZ_ORDER[z]        : raster index (8*row+col) of zigzag position z.
//   ZZ_POS[r]          : zigzag position of raster index r (inverse of ZZ_ORDER).
//   bank_state_e       : lifecycle of one storage bank.
package jpeg_zz_pkg;

  localparam int BLK_DIM  = 8;
  localparam int BLK_SIZE = 64;

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_e;

  localparam logic [5:0] ZZ_ORDER [BLK_SIZE] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
  };

  localparam logic [5:0] ZZ_POS [BLK_SIZE] = '{
     0,  1,  5,  6, 14, 15, 27, 28,
     2,  4,  7, 13, 16, 26, 29, 42,
     3,  8, 12, 17, 25, 30, 41, 43,
     9, 11, 18, 24, 31, 40, 44, 53,
    10, 19, 23, 32, 39, 45, 52, 54,
    20, 22, 33, 38, 46, 51, 55, 60,
    21, 34, 37, 47, 50, 56, 59, 61,
    35, 36, 48, 49, 57, 58, 62, 63
  };

endpackage

// File: rtl/zz_bank.sv
// zz_bank: one 64-entry coefficient bank.
//   Write port : wr_en writes the 8 columns of wr_data into raster row wr_row
//                (column 0 in the MSBs).
//   Read port  : rd_data carries zigzag positions rd_beat*OUT_LANES + l,
//                lane l at [(OUT_LANES-l)*DATA_WIDTH-1 -: DATA_WIDTH]; purely
//                combinational from the registered storage.
// Storage is deliberately not reset.
module zz_bank
  import jpeg_zz_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_LANES  = 8,
  parameter int BEAT_W     = 3
) (
  input  logic                            clock,
  input  logic                            wr_en,
  input  logic [2:0]                      wr_row,
  input  logic [BLK_DIM*DATA_WIDTH-1:0]   wr_data,
  input  logic [BEAT_W-1:0]               rd_beat,
  output logic [OUT_LANES*DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem_q [BLK_SIZE];
  logic [DATA_WIDTH-1:0] mem_d [BLK_SIZE];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int c = 0; c < BLK_DIM; c++) begin
        mem_d[{wr_row, 3'(c)}] = wr_data[(BLK_DIM-c)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_comb begin
    int zz;
    rd_data = '0;
    for (int l = 0; l < OUT_LANES; l++) begin
      zz = int'(rd_beat) * OUT_LANES + l;
      rd_data[(OUT_LANES-l)*DATA_WIDTH-1 -: DATA_WIDTH] = mem_q[ZZ_ORDER[zz[5:0]]];
    end
  end

endmodule

// File: rtl/zigzag_pingpong_buffer.sv
// zigzag_pingpong_buffer: double-buffered 8x8 coefficient buffer that accepts
// raster rows and emits each completed block in zigzag order.
//   clock, reset_n     : clock, asynchronous active-low reset.
//   flush              : synchronous abort of all buffered/partial blocks.
//   in_valid/in_ready  : row handshake; in_row_data holds 8 columns, col 0 MSBs.
//   out_valid/out_ready: beat handshake; out_data holds OUT_LANES zigzag coefs.
//   out_first/out_last : beat 0 / beat BEATS-1 of the draining block.
//   eob_idx            : 1 + zigzag index of last nonzero coef of draining block.
//   bank_full          : per-bank FULL-or-DRAINING status.
// Optional macro ZZ_EOB_DETECT_EN builds the end-of-block detector; without it
// eob_idx is tied to 64.
module zigzag_pingpong_buffer
  import jpeg_zz_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_LANES  = 8
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic                            flush,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [8*DATA_WIDTH-1:0]         in_row_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [OUT_LANES*DATA_WIDTH-1:0] out_data,
  output logic                            out_first,
  output logic                            out_last,
  output logic [6:0]                      eob_idx,
  output logic [1:0]                      bank_full
);

  localparam int BEATS  = BLK_SIZE / OUT_LANES;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  if (OUT_LANES != 1 && OUT_LANES != 2 && OUT_LANES != 4 && OUT_LANES != 8 &&
      OUT_LANES != 16 && OUT_LANES != 32 && OUT_LANES != 64) begin : g_bad_lanes
    $error("zigzag_pingpong_buffer: OUT_LANES must be 1,2,4,8,16,32 or 64");
  end

  bank_state_e       state_q [2];
  bank_state_e       state_d [2];
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [2:0]        row_cnt_q, row_cnt_d;
  logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

  logic wr_fire, rd_fire, last_beat;
  logic [OUT_LANES*DATA_WIDTH-1:0] bank_rd [2];

  assign in_ready  = (state_q[wr_bank_q] == EMPTY) || (state_q[wr_bank_q] == FILLING);
  assign out_valid = (state_q[rd_bank_q] == FULL)  || (state_q[rd_bank_q] == DRAINING);
  assign wr_fire   = in_valid && in_ready;
  assign rd_fire   = out_valid && out_ready;
  assign last_beat = (beat_cnt_q == BEAT_W'(BEATS - 1));

  assign out_first = out_valid && (beat_cnt_q == '0);
  assign out_last  = out_valid && last_beat;
  assign out_data  = bank_rd[rd_bank_q];

  for (genvar b = 0; b < 2; b++) begin : g_bank
    assign bank_full[b] = (state_q[b] == FULL) || (state_q[b] == DRAINING);

    zz_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .OUT_LANES  (OUT_LANES),
      .BEAT_W     (BEAT_W)
    ) u_bank (
      .clock   (clock),
      .wr_en   (wr_fire && !flush && (wr_bank_q == 1'(b))),
      .wr_row  (row_cnt_q),
      .wr_data (in_row_data),
      .rd_beat (beat_cnt_q),
      .rd_data (bank_rd[b])
    );
  end

  // Write and read always target different banks (FILLING/EMPTY vs
  // FULL/DRAINING), so both updates can land in the same cycle.
  always_comb begin
    state_d    = state_q;
    wr_bank_d  = wr_bank_q;
    rd_bank_d  = rd_bank_q;
    row_cnt_d  = row_cnt_q;
    beat_cnt_d = beat_cnt_q;
    if (flush) begin
      state_d[0] = EMPTY;
      state_d[1] = EMPTY;
      wr_bank_d  = 1'b0;
      rd_bank_d  = 1'b0;
      row_cnt_d  = '0;
      beat_cnt_d = '0;
    end else begin
      if (wr_fire) begin
        row_cnt_d          = row_cnt_q + 3'd1;
        state_d[wr_bank_q] = FILLING;
        if (row_cnt_q == 3'd7) begin
          state_d[wr_bank_q] = FULL;
          wr_bank_d          = ~wr_bank_q;
        end
      end
      if (rd_fire) begin
        state_d[rd_bank_q] = DRAINING;
        if (last_beat) begin
          beat_cnt_d         = '0;
          state_d[rd_bank_q] = EMPTY;
          rd_bank_d          = ~rd_bank_q;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q[0] <= EMPTY;
      state_q[1] <= EMPTY;
      wr_bank_q  <= 1'b0;
      rd_bank_q  <= 1'b0;
      row_cnt_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_bank_q  <= wr_bank_d;
      rd_bank_q  <= rd_bank_d;
      row_cnt_q  <= row_cnt_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

`ifdef ZZ_EOB_DETECT_EN
  logic [6:0] eob_q [2];
  logic [6:0] eob_d [2];
  logic [6:0] row_max;

  // Highest (zigzag position + 1) among the nonzero columns of the incoming row.
  always_comb begin
    row_max = '0;
    for (int c = 0; c < BLK_DIM; c++) begin
      if ((in_row_data[(BLK_DIM-c)*DATA_WIDTH-1 -: DATA_WIDTH] != '0) &&
          ((7'(ZZ_POS[{row_cnt_q, 3'(c)}]) + 7'd1) > row_max)) begin
        row_max = 7'(ZZ_POS[{row_cnt_q, 3'(c)}]) + 7'd1;
      end
    end
  end

  // Row 0 starts a fresh block, which clears the running max.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      eob_d[b] = eob_q[b];
      if (flush) begin
        eob_d[b] = '0;
      end else if (wr_fire && (wr_bank_q == 1'(b))) begin
        if (row_cnt_q == 3'd0 || row_max > eob_q[b]) begin
          eob_d[b] = row_max;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      eob_q[0] <= '0;
      eob_q[1] <= '0;
    end else begin
      eob_q <= eob_d;
    end
  end

  assign eob_idx = eob_q[rd_bank_q];
`else
  assign eob_idx = 7'd64;
`endif

endmodule

// File: tb/tb_zigzag_pingpong_buffer.sv
// Bench for zigzag_pingpong_buffer: directed steps, scoreboard of expected
// beats built from an independently generated zigzag walk.
module tb_zigzag_pingpong_buffer;

  localparam int DW    = 8;
  localparam int LANES = 8;
  localparam int BEATS = 64 / LANES;
  localparam int OW    = LANES * DW;
`ifdef ZZ_EOB_DETECT_EN
  localparam bit EOB_EN = 1'b1;
`else
  localparam bit EOB_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          flush = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [8*DW-1:0] in_row_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [OW-1:0] out_data;
  logic          out_first, out_last;
  logic [6:0]    eob_idx;
  logic [1:0]    bank_full;

  zigzag_pingpong_buffer #(.DATA_WIDTH(DW), .OUT_LANES(LANES)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_row_data (in_row_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_first   (out_first),
    .out_last    (out_last),
    .eob_idx     (eob_idx),
    .bank_full   (bank_full)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [OW-1:0] data;
    logic          first;
    logic          last;
    logic [6:0]    eob;
  } beat_t;

  beat_t         sb[$];
  beat_t         exp_b;
  int            vectors = 0;
  int            miscompares = 0;
  int            zz[64];
  logic [DW-1:0] blk[64];
  int            tb_row = 0;
  int            waited;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Zigzag walk along anti-diagonals, independent of the design's table.
  task automatic build_zz();
    int r = 0;
    int c = 0;
    for (int i = 0; i < 64; i++) begin
      zz[i] = r * 8 + c;
      if (((r + c) % 2) == 0) begin
        if (c == 7) r++;
        else if (r == 0) c++;
        else begin r--; c++; end
      end else begin
        if (r == 7) c++;
        else if (c == 0) r++;
        else begin r++; c--; end
      end
    end
  endtask

  task automatic push_block();
    beat_t b;
    int    e = 0;
    for (int z = 0; z < 64; z++) if (blk[zz[z]] != '0) e = z + 1;
    if (!EOB_EN) e = 64;
    for (int k = 0; k < BEATS; k++) begin
      b.data = '0;
      for (int l = 0; l < LANES; l++) b.data[(LANES-l)*DW-1 -: DW] = blk[zz[k*LANES+l]];
      b.first = (k == 0);
      b.last  = (k == BEATS - 1);
      b.eob   = 7'(e);
      sb.push_back(b);
    end
  endtask

  function automatic logic [8*DW-1:0] ramp_row(input int r, input int base);
    logic [8*DW-1:0] d;
    for (int c = 0; c < 8; c++) d[(8-c)*DW-1 -: DW] = DW'(base + 8 * r + c);
    return d;
  endfunction

  // Presents one row; returns the number of cycles spent waiting for in_ready.
  task automatic send_row(input logic [8*DW-1:0] d, output int nwait);
    in_valid    = 1'b1;
    in_row_data = d;
    nwait = 0;
    @(negedge clock);
    while (!in_ready && nwait < 200) begin
      @(negedge clock);
      nwait++;
    end
    chk("in_ready_wait", in_ready, 1'b1);
    if (in_ready) begin
      for (int c = 0; c < 8; c++) blk[tb_row*8+c] = d[(8-c)*DW-1 -: DW];
      tb_row++;
      if (tb_row == 8) begin
        push_block();
        tb_row = 0;
      end
    end
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(posedge clock);
      n++;
    end
    chk(tag, sb.size(), 0);
    @(posedge clock);
    #1;
  endtask

  always @(negedge clock) begin
    if (reset_n && !flush && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", out_valid, 1'b0);
      end else begin
        exp_b = sb.pop_front();
        chk("out_data", out_data, exp_b.data);
        chk("out_first", out_first, exp_b.first);
        chk("out_last", out_last, exp_b.last);
        chk("eob_idx", eob_idx, exp_b.eob);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8*DW-1:0] d;
    logic [OW-1:0]   lit;
    build_zz();

    // Reset state
    repeat (3) @(posedge clock);
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_first", out_first, 1'b0);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_bank_full", bank_full, 2'b00);
    chk("rst_eob", eob_idx, EOB_EN ? 7'd0 : 7'd64);
    reset_n = 1'b1;
    @(posedge clock);
    #1;

    // Single ramp block
    out_ready = 1'b1;
    for (int r = 0; r < 7; r++) send_row(ramp_row(r, 0), waited);
    chk("pre_valid", out_valid, 1'b0);
    send_row(ramp_row(7, 0), waited);
    chk("first_valid", out_valid, 1'b1);
    chk("first_first", out_first, 1'b1);
    chk("first_bank_full", bank_full, 2'b01);
    lit = 64'h00_01_08_10_09_02_03_0A;
    chk("beat0_literal", out_data, lit);
    wait_drain("ramp_drain");

    // Continuous stream of 4 blocks
    for (int b = 0; b < 4; b++) begin
      for (int r = 0; r < 8; r++) begin
        d = {$urandom, $urandom};
        send_row(d, waited);
        chk("stream_no_stall", waited, 0);
      end
    end
    wait_drain("stream_drain");

    // Backpressure: two full banks
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(ramp_row(r, 0), waited);
    for (int r = 0; r < 8; r++) send_row(ramp_row(r, 64), waited);
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("bp_in_ready", in_ready, 1'b0);
      chk("bp_bank_full", bank_full, 2'b11);
      chk("bp_first", out_first, 1'b1);
      chk("bp_hold_data", out_data, sb[0].data);
    end
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    wait_drain("bp_drain");

    // Flush while block 0 drains and block 1 is partial
    out_ready = 1'b0;
    for (int r = 0; r < 8; r++) send_row(ramp_row(r, 0), waited);
    out_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_row(ramp_row(r, 100), waited);
    out_ready = 1'b0;
    flush = 1'b1;
    @(posedge clock);
    #1;
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_bank_full", bank_full, 2'b00);
    sb.delete();
    tb_row = 0;
    out_ready = 1'b1;
    for (int r = 0; r < 8; r++) send_row(ramp_row(r, 20), waited);
    chk("post_flush_first", out_first, 1'b1);
    wait_drain("flush_drain");

    // Sparse block: raster 0 and 9 nonzero
    for (int r = 0; r < 8; r++) begin
      d = '0;
      if (r == 0) d[8*DW-1 -: DW] = 8'd5;
      if (r == 1) d[7*DW-1 -: DW] = 8'd3;
      send_row(d, waited);
    end
    chk("sparse_eob", eob_idx, EOB_EN ? 7'd5 : 7'd64);
    wait_drain("sparse_drain");

    // All-zero block
    for (int r = 0; r < 8; r++) send_row('0, waited);
    chk("zero_eob", eob_idx, EOB_EN ? 7'd0 : 7'd64);
    wait_drain("zero_drain");

    // Reset in the middle of a block
    for (int r = 0; r < 3; r++) send_row(ramp_row(r, 0), waited);
    reset_n = 1'b0;
    #1;
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_bank_full", bank_full, 2'b00);
    sb.delete();
    tb_row = 0;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int r = 0; r < 8; r++) send_row(ramp_row(r, 30), waited);
    chk("midrst_first", out_first, 1'b1);
    wait_drain("midrst_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
